capture_sequencer: RTL and testbench

Arms, triggers and sequences one acquisition through the four-lane ADC storage block. It watches the 32-bit sample stream in the WriteClock domain and detects a level crossing on a selected lane. On a crossing it issues the WriteStrobe edge the storage block needs to start storing. It then tracks the storage state until the buffer has been filled and drained, and either re-arms or returns to idle.

---
 rtl/capture_seq_pkg.sv | 31 +++
 rtl/trigger_detector.sv | 43 ++++
 rtl/capture_sequencer.sv | 128 ++++++++++++
 tb/tb_capture_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/capture_seq_pkg.sv
// capture_seq_pkg: shared encodings and helpers for the capture sequencer.
package capture_seq_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'b000,
        PRIME     = 3'b001,
        WAIT_TRIG = 3'b010,
        STROBE    = 3'b011,
        STORING   = 3'b100,
        DRAINING  = 3'b101
    } seqState_t;

    localparam logic [1:0] LANE_DI  = 2'd0;
    localparam logic [1:0] LANE_DID = 2'd1;
    localparam logic [1:0] LANE_DQ  = 2'd2;
    localparam logic [1:0] LANE_DQD = 2'd3;

    localparam int STROBE_LEN = 2;

    localparam logic [1:0] SS_RESET   = 2'b00;
    localparam logic [1:0] SS_READY   = 2'b01;
    localparam logic [1:0] SS_STORING = 2'b10;
    localparam logic [1:0] SS_SENDING = 2'b11;

    function automatic logic [7:0] laneSelect(input logic [31:0] data, input logic [1:0] lane);
        return lane == LANE_DI  ? data[31:24] :
               lane == LANE_DID ? data[23:16] :
               lane == LANE_DQ  ? data[15:8]  : data[7:0];
    endfunction

endpackage

// File: rtl/trigger_detector.sv
// trigger_detector: latches trigger settings on Load, tracks the previous lane sample, flags a crossing.
module trigger_detector
    import capture_seq_pkg::*;
(
    input  logic        WriteClock,
    input  logic        Reset,
    input  logic        Load,
    input  logic        Sample,
    input  logic [31:0] DataIn,
    input  logic [1:0]  TrigLane,
    input  logic [7:0]  TrigLevel,
    input  logic        TrigRising,
    output logic        Hit
);

    logic [1:0] lane;
    logic [7:0] level;
    logic       rising;
    logic [7:0] prev;
    logic [7:0] current;

    assign current = laneSelect(DataIn, lane);
    assign Hit = Sample && (rising ? (prev < level && current >= level)
                                   : (prev >= level && current < level));

    // Settings and the first reference sample are captured together; afterwards prev follows the lane.
    always_ff @(posedge WriteClock or posedge Reset) begin
        if (Reset) begin
            lane   <= LANE_DI;
            level  <= '0;
            rising <= 1'b0;
            prev   <= '0;
        end else if (Load) begin
            lane   <= TrigLane;
            level  <= TrigLevel;
            rising <= TrigRising;
            prev   <= laneSelect(DataIn, TrigLane);
        end else if (Sample) begin
            prev   <= current;
        end
    end

endmodule

// File: rtl/capture_sequencer.sv
// capture_sequencer: arms, triggers on a lane crossing, strobes storage and follows it to drain.
// Build option CAPTURE_SEQ_AUTO_TRIGGER_EN forces a trigger after AUTO_TIMEOUT cycles in WAIT_TRIG.
module capture_sequencer
    import capture_seq_pkg::*;
#(
    parameter int AUTO_TIMEOUT = 1000000,
    parameter int CNT_W        = 16
) (
    input  logic             WriteClock,
    input  logic             Reset,
    input  logic [31:0]      DataIn,
    input  logic             Arm,
    input  logic             Abort,
    input  logic             Continuous,
    input  logic [1:0]       TrigLane,
    input  logic [7:0]       TrigLevel,
    input  logic             TrigRising,
    input  logic [1:0]       StorageState,
    output logic             WriteStrobe,
    output logic             Busy,
    output logic [2:0]       SeqState,
    output logic             Triggered,
    output logic             AutoTriggered,
    output logic             Error,
    output logic [CNT_W-1:0] CaptureCount
);

    seqState_t state;
    logic      strobeCnt;
    logic      hit;
    logic      autoFire;
    logic      fire;

    assign SeqState = state;
    assign fire = hit || autoFire;

    trigger_detector detector (
        .WriteClock (WriteClock),
        .Reset      (Reset),
        .Load       (state == PRIME),
        .Sample     (state == WAIT_TRIG),
        .DataIn     (DataIn),
        .TrigLane   (TrigLane),
        .TrigLevel  (TrigLevel),
        .TrigRising (TrigRising),
        .Hit        (hit)
    );

`ifdef CAPTURE_SEQ_AUTO_TRIGGER_EN
    localparam logic [23:0] TIMEOUT_LAST = 24'(AUTO_TIMEOUT - 1);
    logic [23:0] waitCnt;

    assign autoFire = state == WAIT_TRIG && waitCnt == TIMEOUT_LAST;

    // Cycles spent in WAIT_TRIG; PRIME always precedes WAIT_TRIG so it clears the count.
    always_ff @(posedge WriteClock or posedge Reset) begin
        if (Reset)
            waitCnt <= '0;
        else if (state == PRIME)
            waitCnt <= '0;
        else if (state == WAIT_TRIG)
            waitCnt <= waitCnt + 24'd1;
    end
`else
    assign autoFire = 1'b0;
`endif

    // Sequencer FSM; Abort outranks everything, a storage reset mid-capture is latched as Error.
    always_ff @(posedge WriteClock or posedge Reset) begin
        if (Reset) begin
            state         <= IDLE;
            strobeCnt     <= 1'b0;
            WriteStrobe   <= 1'b0;
            Busy          <= 1'b0;
            Triggered     <= 1'b0;
            AutoTriggered <= 1'b0;
            Error         <= 1'b0;
            CaptureCount  <= '0;
        end else begin
            Triggered <= 1'b0;
            if (Abort) begin
                state       <= IDLE;
                WriteStrobe <= 1'b0;
                Busy        <= 1'b0;
            end else if ((state == STROBE || state == STORING || state == DRAINING) && StorageState == SS_RESET) begin
                state       <= IDLE;
                WriteStrobe <= 1'b0;
                Busy        <= 1'b0;
                Error       <= 1'b1;
            end else begin
                case (state)
                    IDLE: if (Arm && StorageState == SS_READY) begin
                        state         <= PRIME;
                        Busy          <= 1'b1;
                        Error         <= 1'b0;
                        AutoTriggered <= 1'b0;
                    end
                    PRIME: state <= WAIT_TRIG;
                    WAIT_TRIG: if (fire) begin
                        state         <= STROBE;
                        WriteStrobe   <= 1'b1;
                        Triggered     <= 1'b1;
                        AutoTriggered <= !hit;
                        strobeCnt     <= 1'b0;
                    end
                    STROBE: if (strobeCnt == 1'(STROBE_LEN - 1)) begin
                        state       <= STORING;
                        WriteStrobe <= 1'b0;
                    end else begin
                        strobeCnt <= strobeCnt + 1'b1;
                    end
                    STORING: if (StorageState == SS_SENDING) state <= DRAINING;
                    DRAINING: if (StorageState == SS_READY) begin
                        CaptureCount <= CaptureCount + 1'b1;
                        state        <= Continuous ? PRIME : IDLE;
                        Busy         <= Continuous;
                    end
                    default: begin
                        state       <= IDLE;
                        WriteStrobe <= 1'b0;
                        Busy        <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_capture_sequencer.sv
// tb_capture_sequencer: directed and random stimulus against a transaction-level model of the sequencer.
module tb_capture_sequencer;

    localparam int CNT_W   = 3;
    localparam int TIMEOUT = 16;
`ifdef CAPTURE_SEQ_AUTO_TRIGGER_EN
    localparam bit AUTO_EN = 1'b1;
`else
    localparam bit AUTO_EN = 1'b0;
`endif
    localparam int S_IDLE = 0, S_PRIME = 1, S_WAIT = 2, S_STROBE = 3, S_STORING = 4, S_DRAIN = 5;

    logic             WriteClock = 1'b0;
    logic             Reset;
    logic [31:0]      DataIn;
    logic             Arm, Abort, Continuous;
    logic [1:0]       TrigLane;
    logic [7:0]       TrigLevel;
    logic             TrigRising;
    logic [1:0]       StorageState;
    logic             WriteStrobe, Busy, Triggered, AutoTriggered, Error;
    logic [2:0]       SeqState;
    logic [CNT_W-1:0] CaptureCount;

    int checks = 0;
    int fails = 0;

    int mState, mCount, mTrigCycle, cycle = 0;
    int mLane, mLevel;
    bit mRising, mErr, mAuto, mTrig;
    int samples[$];

    capture_sequencer #(.AUTO_TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .WriteClock    (WriteClock),
        .Reset         (Reset),
        .DataIn        (DataIn),
        .Arm           (Arm),
        .Abort         (Abort),
        .Continuous    (Continuous),
        .TrigLane      (TrigLane),
        .TrigLevel     (TrigLevel),
        .TrigRising    (TrigRising),
        .StorageState  (StorageState),
        .WriteStrobe   (WriteStrobe),
        .Busy          (Busy),
        .SeqState      (SeqState),
        .Triggered     (Triggered),
        .AutoTriggered (AutoTriggered),
        .Error         (Error),
        .CaptureCount  (CaptureCount)
    );

    always #5 WriteClock = ~WriteClock;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cycle, got, exp);
        end
    endtask

    function automatic int laneByte(input int lane);
        return int'((DataIn >> (8 * (3 - lane))) & 32'hFF);
    endfunction

    task automatic modelReset();
        mState = S_IDLE;
        mCount = 0;
        mErr = 0;
        mAuto = 0;
        mTrig = 0;
        samples.delete();
    endtask

    // Predicts the state after the coming edge from the inputs the DUT will sample.
    task automatic modelStep();
        int cur, prv;
        bit hit, forced;
        mTrig = 0;
        if (Abort) mState = S_IDLE;
        else case (mState)
            S_IDLE: if (Arm && StorageState == 2'b01) begin
                mState = S_PRIME; mErr = 0; mAuto = 0;
            end
            S_PRIME: begin
                mLane = int'(TrigLane); mLevel = int'(TrigLevel); mRising = TrigRising;
                samples = {laneByte(int'(TrigLane))};
                mState = S_WAIT;
            end
            S_WAIT: begin
                samples.push_back(laneByte(mLane));
                cur = samples[$];
                prv = samples[$-1];
                hit = mRising ? (prv < mLevel && cur >= mLevel) : (prv >= mLevel && cur < mLevel);
                forced = AUTO_EN && (samples.size() - 1 == TIMEOUT);
                if (hit || forced) begin
                    mState = S_STROBE; mTrig = 1; mAuto = !hit; mTrigCycle = cycle;
                end
            end
            default: begin
                if (StorageState == 2'b00) begin
                    mState = S_IDLE; mErr = 1;
                end else if (mState == S_STROBE && cycle - mTrigCycle == 2) mState = S_STORING;
                else if (mState == S_STORING && StorageState == 2'b11) mState = S_DRAIN;
                else if (mState == S_DRAIN && StorageState == 2'b01) begin
                    mCount = (mCount + 1) % (1 << CNT_W);
                    mState = Continuous ? S_PRIME : S_IDLE;
                end
            end
        endcase
        cycle++;
    endtask

    task automatic checkAll();
        checkEq("SeqState", 32'(SeqState), mState);
        checkEq("WriteStrobe", 32'(WriteStrobe), 32'(mState == S_STROBE));
        checkEq("Busy", 32'(Busy), 32'(mState != S_IDLE));
        checkEq("Triggered", 32'(Triggered), 32'(mTrig));
        checkEq("AutoTriggered", 32'(AutoTriggered), 32'(mAuto));
        checkEq("Error", 32'(Error), 32'(mErr));
        checkEq("CaptureCount", 32'(CaptureCount), mCount);
    endtask

    task automatic tick();
        modelStep();
        @(posedge WriteClock);
        @(negedge WriteClock);
        checkAll();
    endtask

    task automatic setLane(input int lane, input logic [7:0] v);
        DataIn = $urandom;
        DataIn[31 - 8 * lane -: 8] = v;
    endtask

    task automatic armCapture(input int lane, input logic [7:0] level, input logic rising, input logic [7:0] v);
        TrigLane = 2'(lane); TrigLevel = level; TrigRising = rising; StorageState = 2'b01;
        setLane(lane, v); Arm = 1; tick(); Arm = 0;
        setLane(lane, v); tick();
    endtask

    task automatic drainStorage();
        StorageState = 2'b10; repeat (2) tick();
        StorageState = 2'b11; repeat (2) tick();
        StorageState = 2'b01; tick();
    endtask

    initial begin
        Arm = 0; Abort = 0; Continuous = 0; TrigLane = 0; TrigLevel = 0; TrigRising = 1;
        StorageState = 2'b01; DataIn = 0; Reset = 1;
        modelReset();
        @(negedge WriteClock);
        checkAll();
        Reset = 0;
        tick();

        // Rising on DI at 0x80, level already above at arm time, settings changed mid-capture.
        armCapture(0, 8'h80, 1'b1, 8'h90);
        TrigLevel = 8'h00; TrigLane = 2; TrigRising = 0;
        setLane(0, 8'h90); tick();
        setLane(0, 8'h70); tick();
        setLane(0, 8'h7F); tick();
        setLane(0, 8'h80); tick();
        repeat (2) tick();
        drainStorage();
        tick();

        // Continuous capture, falling on DQD at 0x20, twice.
        Continuous = 1;
        armCapture(3, 8'h20, 1'b0, 8'h40);
        for (int k = 0; k < 2; k++) begin
            setLane(3, 8'h30); tick();
            setLane(3, 8'h10); tick();
            setLane(3, 8'h40); repeat (2) tick();
            if (k == 1) Continuous = 0;
            drainStorage();
            tick();
        end

        // Abort racing a crossing, then Arm while storage is sending.
        armCapture(1, 8'h50, 1'b1, 8'h10);
        setLane(1, 8'h60); Abort = 1; tick(); Abort = 0; tick();
        StorageState = 2'b11; Arm = 1; tick(); Arm = 0; tick();

        // Storage drops to reset while storing, next Arm clears Error.
        armCapture(2, 8'h40, 1'b1, 8'h00);
        setLane(2, 8'hF0); tick();
        repeat (2) tick();
        StorageState = 2'b00; tick();
        StorageState = 2'b01; tick();
        Arm = 1; tick(); Arm = 0; tick();
        Abort = 1; tick(); Abort = 0; tick();

        // Asynchronous reset while strobing.
        armCapture(0, 8'h80, 1'b1, 8'h00);
        setLane(0, 8'hFF); tick();
        Reset = 1; #1;
        checkEq("AsyncSeqState", 32'(SeqState), S_IDLE);
        checkEq("AsyncWriteStrobe", 32'(WriteStrobe), 0);
        checkEq("AsyncCaptureCount", 32'(CaptureCount), 0);
        modelReset();
        #1 Reset = 0;
        tick();

        // Flat input: forced trigger only with the auto option.
        armCapture(0, 8'h80, 1'b1, 8'h10);
        repeat (20) begin setLane(0, 8'h10); tick(); end
        Abort = 1; tick(); Abort = 0; tick();

        // Real crossing on the timeout cycle must win over the forced trigger.
        armCapture(0, 8'h80, 1'b1, 8'h10);
        repeat (TIMEOUT - 1) begin setLane(0, 8'h10); tick(); end
        setLane(0, 8'h90); tick();
        repeat (2) tick();
        drainStorage();
        tick();

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            Arm = ($urandom_range(0, 7) == 0);
            Abort = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 31) == 0) Continuous = 1'($urandom_range(0, 1));
            TrigLane = 2'($urandom);
            TrigLevel = 8'($urandom);
            TrigRising = 1'($urandom);
            DataIn = $urandom;
            if ($urandom_range(0, 3) == 0) StorageState = (StorageState == 2'b11) ? 2'b01 : StorageState + 2'd1;
            if ($urandom_range(0, 149) == 0) StorageState = 2'b00;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
